div_iter_unit: RTL and testbench

- Multi-cycle radix-2 restoring integer divider; the responder side of the EX-stage ALU divide handshake.
- Accepts a one-cycle start pulse with dividend/divisor/sign.
- Iterates one quotient bit per cycle, then returns {remainder, quotient} with a one-cycle ready pulse, matching the HI/LO packing used by hilo.
- Supports abort by pipeline flush.

---
 rtl/div_iter_unit.sv | 157 +++++++++++++++
 tb/tb_div_iter_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle radix-2 restoring integer divider.
// Starts on a one-cycle valid pulse and produces one quotient bit per cycle.
// After a fixed WIDTH+1 cycle latency it returns {remainder, quotient}
// with a one-cycle ready pulse. A flush abandons the operation in flight.
//
// state | meaning
// IDLE  | waiting for a start pulse
// BUSY  | iterating, one quotient bit per cycle
// DONE  | result registered, ready pulse this cycle
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               valid,
  input  logic               sign,
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               start;
  logic               last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   fix_rem, fix_quo;

  assign start     = (state_q == S_IDLE) && valid && !flush;
  assign last_iter = (state_q == S_BUSY) && (cnt_q == CW'(WIDTH - 1));

  // Operand magnitudes: the iteration itself is always unsigned.
  assign a_mag = (sign && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign && b[WIDTH-1]) ? -b : b;

  // One restoring step: shift in the next dividend bit, trial subtract,
  // keep the difference only when it did not borrow.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  // Truncating division: quotient sign from both operands, remainder
  // sign follows the dividend.
  assign fix_quo = negq_q ? -step_quo : step_quo;
  assign fix_rem = negr_q ? -step_rem : step_rem;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Status outputs decoded from the current state.
  always_comb begin
    ready = (state_q == S_DONE);
    busy  = (state_q == S_BUSY);
  end

  assign result = result_q;

  // Datapath next values: capture on start, step while busy, publish on last step.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_raw_d  = a_raw_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    result_d = result_q;
    if (start) begin
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = a_mag;
      dvs_d   = b_mag;
      a_raw_d = a;
      negq_d  = sign && (a[WIDTH-1] ^ b[WIDTH-1]);
      negr_d  = sign && a[WIDTH-1];
      div0_d  = (b == '0);
    end else if ((state_q == S_BUSY) && !flush) begin
      cnt_d = cnt_q + CW'(1);
      rem_d = step_rem;
      quo_d = step_quo;
      if (last_iter) begin
        // Divide by zero reports the raw dividend and an all-ones quotient
        // regardless of operand signs.
        result_d = div0_q ? {a_raw_q, {WIDTH{1'b1}}} : {fix_rem, fix_quo};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_raw_q  <= a_raw_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Testbench for div_iter_unit: directed vectors, flush/restart, ignored
// valids, back-to-back operation, random operands and async reset.
module tb_div_iter_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          valid;
  logic          sign;
  logic          ready;
  logic          busy;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .sign   (sign),
    .ready  (ready),
    .busy   (busy),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain truncating integer division on 64-bit integers.
  function automatic logic [63:0] ref_div(input logic [31:0] aa, input logic [31:0] bb,
                                          input logic s);
    longint sa, sb, q, r;
    if (bb == 32'd0) return {aa, 32'hFFFF_FFFF};
    if (s) begin
      sa = $signed(aa);
      sb = $signed(bb);
    end else begin
      sa = $signed({1'b0, aa});
      sb = $signed({1'b0, bb});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drive a start pulse in the current cycle (cycle 0).
  task automatic drive_start(input logic [31:0] aa, input logic [31:0] bb, input logic ss);
    @(negedge clk);
    a     = aa;
    b     = bb;
    sign  = ss;
    valid = 1'b1;
  endtask

  // Observe cycles 1..max_cyc after a start; operands are scrambled after sampling.
  task automatic wait_done(input int max_cyc, output int rdy_cyc, output int rdy_cnt,
                           output int busy_cnt, output int first_busy, output int last_busy,
                           output logic [63:0] res_at_rdy);
    rdy_cyc    = -1;
    rdy_cnt    = 0;
    busy_cnt   = 0;
    first_busy = -1;
    last_busy  = -1;
    res_at_rdy = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        valid = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sign  = 1'($urandom_range(0, 1));
      end
      if (ready) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc    = c;
          res_at_rdy = result;
        end
      end
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
        last_busy = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; valid = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (result !== 64'd0) $display("FAIL reset_result: got %h want 0", result);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'h0000_1234};
    logic [31:0] tb [6] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h10, 32'd0};
    logic        ts [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] te [6] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                            {32'h1, 32'h7FFF_FFFC}, {32'h0, 32'h8000_0000},
                            {32'hF, 32'h0FFF_FFFF}, {32'h1234, 32'hFFFF_FFFF}};
    int rc, rn, bc, fb, lb;
    logic [63:0] rr;
    for (int i = 0; i < 6; i++) begin
      drive_start(ta[i], tb[i], ts[i]);
      wait_done(40, rc, rn, bc, fb, lb, rr);
      n_checks++;
      if (rc != W + 1 || rn != 1 || bc != W || fb != 1 || lb != W)
        $display("FAIL dir%0d_timing: ready_cyc=%0d ready_cnt=%0d busy_cnt=%0d busy=%0d..%0d want ready_cyc=%0d once busy=1..%0d",
                 i, rc, rn, bc, fb, lb, W + 1, W);
      else n_pass++;
      n_checks++;
      if (rr !== te[i]) $display("FAIL dir%0d_result: got %h want %h", i, rr, te[i]);
      else n_pass++;
      n_checks++;
      if (result !== te[i]) $display("FAIL dir%0d_hold_c40: got %h want %h", i, result, te[i]);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [63:0] prior, res11, resr;
    logic        busy10, busy11;
    int          first, nrdy;
    prior = result;
    first = -1; nrdy = 0; busy10 = 1'b0; busy11 = 1'b1; res11 = '0; resr = '0;
    drive_start(32'd100, 32'd7, 1'b0);
    for (int c = 1; c <= 12 + W + 6; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
      if (c == 10) begin busy10 = busy; flush = 1'b1; end
      if (c == 11) begin flush = 1'b0; busy11 = busy; res11 = result; end
      if (c == 12) begin a = 32'd9; b = 32'd3; sign = 1'b0; valid = 1'b1; end
      if (c == 13) begin valid = 1'b0; a = $urandom; b = $urandom; end
      if (ready) begin
        nrdy++;
        if (first < 0) begin first = c; resr = result; end
      end
    end
    n_checks++;
    if (busy10 !== 1'b1) $display("FAIL flush_busy_c10: got %b want 1", busy10);
    else n_pass++;
    n_checks++;
    if (busy11 !== 1'b0) $display("FAIL flush_busy_c11: got %b want 0", busy11);
    else n_pass++;
    n_checks++;
    if (res11 !== prior) $display("FAIL flush_result_kept: got %h want %h", res11, prior);
    else n_pass++;
    n_checks++;
    if (first != 45 || nrdy != 1)
      $display("FAIL flush_restart_timing: ready_cyc=%0d count=%0d want 45 once", first, nrdy);
    else n_pass++;
    n_checks++;
    if (resr !== {32'd0, 32'd3}) $display("FAIL flush_restart_result: got %h want %h", resr, {32'd0, 32'd3});
    else n_pass++;
  endtask

  task automatic test_flush_vs_valid();
    logic [63:0] prior;
    logic        busy1;
    int          nrdy;
    prior = result;
    nrdy  = 0;
    @(negedge clk);
    a = 32'd50; b = 32'd5; sign = 1'b0; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    busy1 = busy;
    for (int c = 0; c < W + 6; c++) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL flushvalid_busy: got %b want 0", busy1);
    else n_pass++;
    n_checks++;
    if (nrdy != 0 || result !== prior)
      $display("FAIL flushvalid_noop: ready_cnt=%0d result=%h want 0 and %h", nrdy, result, prior);
    else n_pass++;
  endtask

  task automatic test_valid_during_busy();
    logic [63:0] exp, resr;
    int          first, nrdy;
    exp = ref_div(32'd200, 32'd9, 1'b0);
    first = -1; nrdy = 0; resr = '0;
    drive_start(32'd200, 32'd9, 1'b0);
    for (int c = 1; c <= W + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin valid = 1'b0; a = $urandom; b = $urandom; end
      if (c == 5) begin a = 32'd1; b = 32'd1; sign = 1'b1; valid = 1'b1; end
      if (c == 6) valid = 1'b0;
      if (ready) begin
        nrdy++;
        if (first < 0) begin first = c; resr = result; end
      end
    end
    n_checks++;
    if (first != W + 1 || nrdy != 1)
      $display("FAIL vbusy_timing: ready_cyc=%0d count=%0d want %0d once", first, nrdy, W + 1);
    else n_pass++;
    n_checks++;
    if (resr !== exp) $display("FAIL vbusy_result: got %h want %h", resr, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp1, exp2, res1, res2;
    logic        busy_after;
    int          r1, r2, nrdy;
    exp1 = ref_div(32'hDEAD_BEEF, 32'd1234, 1'b0);
    exp2 = ref_div(32'hF000_0001, 32'hFFFF_FFFD, 1'b1);
    r1 = -1; r2 = -1; nrdy = 0; res1 = '0; res2 = '0; busy_after = 1'b1;
    drive_start(32'hDEAD_BEEF, 32'd1234, 1'b0);
    for (int c = 1; c <= 2 * W + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin valid = 1'b0; a = $urandom; b = $urandom; end
      if (c == W + 1) begin a = 32'd77; b = 32'd7; sign = 1'b0; valid = 1'b1; end
      if (c == W + 2) begin
        busy_after = busy;
        a = 32'hF000_0001; b = 32'hFFFF_FFFD; sign = 1'b1; valid = 1'b1;
      end
      if (c == W + 3) begin valid = 1'b0; a = $urandom; b = $urandom; end
      if (ready) begin
        nrdy++;
        if (nrdy == 1) begin r1 = c; res1 = result; end
        if (nrdy == 2) begin r2 = c; res2 = result; end
      end
    end
    n_checks++;
    if (r1 != W + 1 || res1 !== exp1) $display("FAIL b2b_first: cyc=%0d res=%h want cyc=%0d res=%h", r1, res1, W + 1, exp1);
    else n_pass++;
    n_checks++;
    if (busy_after !== 1'b0) $display("FAIL b2b_valid_in_done: busy=%b want 0", busy_after);
    else n_pass++;
    n_checks++;
    if (r2 != 2 * W + 3 || nrdy != 2 || res2 !== exp2)
      $display("FAIL b2b_second: cyc=%0d cnt=%0d res=%h want cyc=%0d cnt=2 res=%h", r2, nrdy, res2, 2 * W + 3, exp2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] exp, rr;
    int          rc, rn, bc, fb, lb;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = -32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      exp = ref_div(ra, rb, rs);
      drive_start(ra, rb, rs);
      wait_done(W + 2, rc, rn, bc, fb, lb, rr);
      n_checks++;
      if (rc != W + 1 || rr !== exp)
        $display("FAIL rand%0d: a=%h b=%h s=%b cyc=%0d got %h want cyc=%0d %h", i, ra, rb, rs, rc, rr, W + 1, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic        busy_before;
    logic [63:0] exp, rr;
    int          rc, rn, bc, fb, lb;
    busy_before = 1'b0;
    drive_start(32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) valid = 1'b0;
    end
    busy_before = busy;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy_before !== 1'b1) $display("FAIL arst_busy_before: got %b want 1", busy_before);
    else n_pass++;
    n_checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0)
      $display("FAIL arst_immediate: ready=%b busy=%b result=%h want 0 0 0", ready, busy, result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp = ref_div(32'hFFFF_FF00, 32'd10, 1'b1);
    drive_start(32'hFFFF_FF00, 32'd10, 1'b1);
    wait_done(W + 3, rc, rn, bc, fb, lb, rr);
    n_checks++;
    if (rc != W + 1 || rn != 1 || rr !== exp)
      $display("FAIL arst_after: cyc=%0d cnt=%0d got %h want cyc=%0d once %h", rc, rn, rr, W + 1, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_flush_vs_valid();
    test_valid_during_busy();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
